// File: rtl/aes_round_scheduler.sv
// Arbitrates two requesters onto one iterative AES round datapath and sequences
// the rounds, holding each final block until the consumer takes it.
module aes_round_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int NR128   = 10,
  parameter int NR192   = 12,
  parameter int NR256   = 14
) (
  input  logic         clk,
  input  logic         reset,

  input  logic         a_valid,
  output logic         a_ready,
  input  logic [1:0]   a_sel,
  input  logic         a_dir,
  input  logic [127:0] a_data,

  input  logic         b_valid,
  output logic         b_ready,
  input  logic [1:0]   b_sel,
  input  logic         b_dir,
  input  logic [127:0] b_data,

  output logic [127:0] rnd_state,
  output logic [3:0]   rnd_idx,
  output logic [1:0]   rnd_sel,
  output logic         rnd_dir,
  output logic         rnd_last,
  input  logic [127:0] rnd_next,

  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_id,
  output logic         busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q;
  logic [127:0]      blk_q;
  logic [127:0]      out_data_q;
  logic [3:0]        cnt_q;
  logic [3:0]        cnt_d;
  logic [1:0]        sel_q;
  logic              dir_q;
  logic [ID_W-1:0]   id_q;
  logic              last_q;
  logic              out_valid_q;
  logic [3:0]        round_limit;
  logic              grant_a;
  logic              grant_b;

  // NOTE: every branch of this case assigns round_limit, so no latch is inferred.
  always_comb begin
    case (sel_q)
      2'b00:   round_limit = 4'(NR128);
      2'b01:   round_limit = 4'(NR192);
      default: round_limit = 4'(NR256);
    endcase
  end

  // Round-robin: last_q names the most recently granted requester.
  assign grant_a = (state_q == IDLE) && a_valid && (!b_valid || last_q);
  assign grant_b = (state_q == IDLE) && b_valid && (!a_valid || !last_q);
  assign cnt_d   = cnt_q + 4'd1;

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign rnd_state = blk_q;
  assign rnd_idx   = cnt_q;
  assign rnd_sel   = sel_q;
  assign rnd_dir   = dir_q;
  assign rnd_last  = (state_q == ROUND) && (cnt_q == round_limit);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = id_q;
  assign busy      = (state_q != IDLE);

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      // NOTE: the wide block registers are cleared too, so the datapath never sees X after reset.
      blk_q       <= '0;
      out_data_q  <= '0;
      cnt_q       <= '0;
      sel_q       <= 2'b00;
      dir_q       <= 1'b0;
      id_q        <= '0;
      last_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_a || grant_b) begin
            blk_q   <= grant_b ? b_data : a_data;
            sel_q   <= grant_b ? b_sel  : a_sel;
            dir_q   <= grant_b ? b_dir  : a_dir;
            id_q    <= grant_b;
            last_q  <= grant_b;
            cnt_q   <= '0;
            state_q <= ROUND;
          end
        end
        ROUND: begin
          blk_q <= rnd_next;
          if (rnd_last) begin
            // Counter returns to 0 so rnd_idx reads 0 outside ROUND.
            out_data_q  <= rnd_next;
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Bench for aes_round_scheduler: drives a behavioural AES round function and
// compares the scheduler against a cycle-timestamp job model every cycle.
module tb_aes_round_scheduler;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         a_valid = 1'b0, b_valid = 1'b0;
  logic         a_ready, b_ready;
  logic [1:0]   a_sel = 2'b00, b_sel = 2'b00;
  logic         a_dir = 1'b0, b_dir = 1'b0;
  logic [127:0] a_data = '0, b_data = '0;
  logic [127:0] rnd_state, rnd_next;
  logic [3:0]   rnd_idx;
  logic [1:0]   rnd_sel;
  logic         rnd_dir, rnd_last;
  logic         out_valid, out_id, busy;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;

  always #5 clk = ~clk;

  aes_round_scheduler dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_sel(a_sel), .a_dir(a_dir), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_sel(b_sel), .b_dir(b_dir), .b_data(b_data),
    .rnd_state(rnd_state), .rnd_idx(rnd_idx), .rnd_sel(rnd_sel), .rnd_dir(rnd_dir),
    .rnd_last(rnd_last), .rnd_next(rnd_next),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .busy(busy)
  );

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    check(name, 128'(act), 128'(exp));
  endtask

  // ---------------- AES reference round function ----------------
  logic [7:0]   sbox [256];
  logic [7:0]   inv_sbox [256];
  logic [127:0] rk [3][15];
  bit           tables_ok = 1'b0;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic int mode_of(input logic [1:0] sel);
    return (sel == 2'b00) ? 0 : (sel == 2'b01) ? 1 : 2;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
    logic [127:0] o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv ? inv_sbox[gb(s, i)] : sbox[gb(s, i)];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
    logic [127:0] o = '0;
    for (int i = 0; i < 16; i++) begin
      int r = i % 4;
      int c = i / 4;
      int src = inv ? (c - r + 4) % 4 : (c + r) % 4;
      o[127-8*i -: 8] = gb(s, r + 4*src);
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input bit inv);
    logic [127:0] o = '0;
    logic [7:0] m [4];
    if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        logic [7:0] acc = 8'h00;
        for (int j = 0; j < 4; j++) acc ^= gmul(m[(j - r + 4) % 4], gb(s, 4*c + j));
        o[127-8*(4*c+r) -: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [3:0] idx,
                                            input logic [1:0] sel, input logic dir, input bit ok);
    int m  = mode_of(sel);
    int nr = 10 + 2*m;
    int i  = int'(idx);
    if (!ok || i > nr) return s;
    if (!dir) begin
      if (i == 0)  return s ^ rk[m][0];
      if (i == nr) return shift_rows(sub_bytes(s, 1'b0), 1'b0) ^ rk[m][nr];
      return mix_columns(shift_rows(sub_bytes(s, 1'b0), 1'b0), 1'b0) ^ rk[m][i];
    end
    if (i == 0)  return s ^ rk[m][nr];
    if (i == nr) return sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk[m][0];
    return mix_columns(sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk[m][nr-i], 1'b1);
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] d, input logic [1:0] sel, input logic dir);
    logic [127:0] s = d;
    for (int r = 0; r <= 10 + 2*mode_of(sel); r++) s = round_fn(s, 4'(r), sel, dir, 1'b1);
    return s;
  endfunction

  // Key for each mode is the byte ramp 00,01,02,... truncated to 16/24/32 bytes.
  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] inv;
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(i));
      sbox[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int i = 0; i < 256; i++) inv_sbox[sbox[i]] = 8'(i);
    for (int m = 0; m < 3; m++) begin
      int nk;
      int nr;
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rcon;
      nk = 4 + 2*m;
      nr = nk + 6;
      rcon = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      for (int i = nk; i < 4*(nr+1); i++) begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
          rcon = xt(rcon);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r <= nr; r++) rk[m][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    tables_ok = 1'b1;
  end

  assign rnd_next = round_fn(rnd_state, rnd_idx, rnd_sel, rnd_dir, tables_ok);

  // ---------------- Job model: one active job described by its grant cycle ----------------
  int           cyc = 0;
  bit           m_init = 1'b0;
  bit           m_active = 1'b0;
  bit           m_last = 1'b1;
  int           m_t = 0;
  int           m_nr = 0;
  logic         m_id = 1'b0;
  logic [1:0]   m_sel = 2'b00;
  logic         m_dir = 1'b0;
  logic [127:0] m_result = '0;

  logic         m_pick_b;
  logic [1:0]   m_req_sel;
  logic         m_req_dir;
  logic [127:0] m_req_data;
  assign m_pick_b   = b_valid && (!a_valid || !m_last);
  assign m_req_sel  = m_pick_b ? b_sel  : a_sel;
  assign m_req_dir  = m_pick_b ? b_dir  : a_dir;
  assign m_req_data = m_pick_b ? b_data : a_data;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_init   <= 1'b1;
      m_active <= 1'b0;
      m_last   <= 1'b1;
    end else if (m_init) begin
      if (m_active) begin
        if (cyc >= m_t + 2 + m_nr && out_ready) m_active <= 1'b0;
      end else if (a_valid || b_valid) begin
        m_active <= 1'b1;
        m_t      <= cyc;
        m_id     <= m_pick_b;
        m_last   <= m_pick_b;
        m_sel    <= m_req_sel;
        m_dir    <= m_req_dir;
        m_nr     <= 10 + 2*mode_of(m_req_sel);
        m_result <= aes_ref(m_req_data, m_req_sel, m_req_dir);
      end
    end
  end

  logic       e_ov, e_last, e_ar, e_br;
  logic [3:0] e_idx;
  assign e_ov   = m_active && (cyc >= m_t + 2 + m_nr);
  assign e_last = m_active && (cyc == m_t + 1 + m_nr);
  assign e_idx  = (m_active && cyc <= m_t + 1 + m_nr) ? 4'(cyc - m_t - 1) : 4'd0;
  assign e_ar   = !m_active && a_valid && (!b_valid || m_last);
  assign e_br   = !m_active && b_valid && (!a_valid || !m_last);

  always @(negedge clk) begin
    if (m_init && tables_ok) begin
      check_b("busy", busy, m_active);
      check_b("out_valid", out_valid, e_ov);
      check("rnd_idx", 128'(rnd_idx), 128'(e_idx));
      check_b("rnd_last", rnd_last, e_last);
      check_b("a_ready", a_ready, e_ar);
      check_b("b_ready", b_ready, e_br);
      if (m_active) begin
        check("rnd_sel", 128'(rnd_sel), 128'(m_sel));
        check_b("rnd_dir", rnd_dir, m_dir);
      end
      if (e_ov) begin
        check("out_data", out_data, m_result);
        check_b("out_id", out_id, m_id);
      end
    end
  end

  // ---------------- Directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input bit is_b, input logic [1:0] sel, input logic dir, input logic [127:0] data);
    int n = 0;
    if (is_b) begin
      b_sel = sel; b_dir = dir; b_data = data; b_valid = 1'b1;
    end else begin
      a_sel = sel; a_dir = dir; a_data = data; a_valid = 1'b1;
    end
    #1;
    while (!(is_b ? b_ready : a_ready) && n < 64) begin
      tick();
      n++;
    end
    check_b("grant_timeout", n < 64, 1'b1);
    tick();
    if (is_b) b_valid = 1'b0;
    else      a_valid = 1'b0;
  endtask

  // Called in the first cycle after acceptance; returns cycles from acceptance to out_valid.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    check_b("rst_busy", busy, 1'b0);
    check_b("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 128'h0);
    check("rst_rnd_state", rnd_state, 128'h0);
    check("rst_rnd_idx", 128'(rnd_idx), 128'h0);
    check("rst_rnd_sel", 128'(rnd_sel), 128'h0);
    check_b("rst_out_id", out_id, 1'b0);

    // Single A encrypt, 128-bit key
    start_job(1'b0, 2'b00, 1'b0, PT);
    wait_result(lat);
    check("lat128", 128'(lat), 128'd12);
    check("ct128", out_data, CT128);
    check_b("id128", out_id, 1'b0);
    accept();

    // Mode-01 job aborted by reset at round 6
    start_job(1'b0, 2'b01, 1'b0, PT);
    n = 0;
    while (rnd_idx != 4'd6 && n < 40) begin
      tick();
      n++;
    end
    check_b("idx6_reached", n < 40, 1'b1);
    reset = 1'b1;
    tick();
    check_b("abort_busy", busy, 1'b0);
    check_b("abort_out_valid", out_valid, 1'b0);
    check("abort_rnd_idx", 128'(rnd_idx), 128'h0);
    reset = 1'b0;

    // Fresh mode-01 job; requester inputs change right after acceptance
    start_job(1'b0, 2'b01, 1'b0, PT);
    a_sel  = 2'b00;
    a_data = ~PT;
    wait_result(lat);
    check("lat192", 128'(lat), 128'd14);
    check("ct192", out_data, CT192);
    accept();

    // B decrypt with a 256-bit key (sel 11), stepping through every round index
    start_job(1'b1, 2'b11, 1'b1, CT256);
    for (int k = 0; k <= 14; k++) begin
      check("dec_idx", 128'(rnd_idx), 128'(k));
      check_b("dec_last", rnd_last, k == 14);
      tick();
    end
    check_b("dec_valid_16", out_valid, 1'b1);
    check("pt256", out_data, PT);
    check_b("id256", out_id, 1'b1);
    accept();

    // Backpressure in DONE with B waiting
    start_job(1'b0, 2'b00, 1'b0, PT);
    wait_result(lat);
    b_sel = 2'b00; b_dir = 1'b0; b_data = PT; b_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_b("bp_valid", out_valid, 1'b1);
      check("bp_data", out_data, CT128);
      check_b("bp_id", out_id, 1'b0);
      check_b("bp_a_ready", a_ready, 1'b0);
      check_b("bp_b_ready", b_ready, 1'b0);
      tick();
    end
    b_valid = 1'b0;
    a_sel = 2'b00; a_dir = 1'b0; a_data = PT; a_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    check_b("no_grant_on_accept", a_ready, 1'b0);
    tick();
    out_ready = 1'b0;
    check_b("grant_after_accept", a_ready, 1'b1);
    check_b("idle_after_accept", busy, 1'b0);
    tick();
    a_valid = 1'b0;
    wait_result(lat);
    check("lat_after_bp", 128'(lat), 128'd12);
    accept();

    // Simultaneous requests from reset, held valid: grants alternate A, B, A, B
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    a_sel = 2'b00; a_dir = 1'b0; a_data = PT; a_valid = 1'b1;
    b_sel = 2'b01; b_dir = 1'b0; b_data = PT; b_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    check_b("tie_a_ready", a_ready, 1'b1);
    check_b("tie_b_ready", b_ready, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!out_valid && n < 64) begin
        tick();
        n++;
      end
      check_b("alt_timeout", n < 64, 1'b1);
      check_b("alt_id", out_id, k[0]);
      check("alt_data", out_data, k[0] ? CT192 : CT128);
      if (k == 3) begin
        a_valid = 1'b0;
        b_valid = 1'b0;
      end
      tick();
    end
    out_ready = 1'b0;
    repeat (3) tick();
    check_b("final_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_round_scheduler.md
Name: aes_round_scheduler

Overview:
- Sequences one shared iterative AES round datapath between two requesters (port A, port B), each issuing a 128-bit block with a key-size mode and a direction.
- Owns the round state register and round counter, and drives the round index, direction and mode to the external combinational round function.
- Holds each result until the consumer accepts it.
- Sits between the stimulus/control logic and the AESEncrypt/AESDecrypt-style round datapath.

Parameters:
- NUM_REQ, 2, number of requesters. Fixed at 2; other values are unsupported.
- NR128, 10, round count for mode 00.
- NR192, 12, round count for mode 01.
- NR256, 14, round count for modes 10 and 11.

Ports:
- clk  in  1  clock. Everything is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- a_valid  in  1  requester A has a job.
- a_ready  out  1  job A is accepted this cycle.
- a_sel  in  2  key mode (00→128, 01→192, 1x→256).
- a_dir  in  1  0 = encrypt, 1 = decrypt.
- a_data  in  128  input block.
- b_valid, b_ready, b_sel, b_dir, b_data: same as the A ports, for requester B.
- rnd_state  out  128  current state presented to the round function.
- rnd_idx  out  4  round index being computed (0..Nr).
- rnd_sel  out  2  latched mode of the active job.
- rnd_dir  out  1  latched direction of the active job.
- rnd_last  out  1  high when rnd_idx == Nr.
- rnd_next  in  128  round-function result for (rnd_state, rnd_idx). Combinational, same cycle.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  128  final block.
- out_id  out  1  0 = from A, 1 = from B.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- States: IDLE, ROUND, DONE.
- Reset values:
  - state = IDLE.
  - All outputs 0, except rnd_sel = 00.
  - Round counter = 0.
  - Round-robin pointer `last` = 1, so A wins the first tie.
- IDLE:
  - a_ready / b_ready are combinational and only ever asserted in IDLE; at most one is high.
  - Arbitration:
    - Grant A if a_valid && (!b_valid || last == 1).
    - Grant B if b_valid && (!a_valid || last == 0).
  - On grant:
    - Latch data into the state register, latch sel/dir/id.
    - Set the counter to 0 and `last` = granted id.
    - Go to ROUND.
  - A non-granted valid must be held by its requester; the scheduler does not drop it.
- ROUND:
  - rnd_state = state register; rnd_idx = counter.
  - Each cycle: state register ← rnd_next, counter += 1.
  - When counter == Nr (rnd_last high): capture rnd_next into out_data and go to DONE.
  - Nr comes from the latched sel: 00→NR128, 01→NR192, else NR256.
  - rnd_dir is passed through unchanged. The datapath is responsible for the decrypt key ordering.
- Latency:
  - Handshake in cycle t.
  - Rounds occupy cycles t+1 .. t+1+Nr.
  - out_valid is high from t+2+Nr: 12 / 14 / 16 cycles after acceptance for 128 / 192 / 256.
- DONE:
  - out_valid = 1; out_data and out_id are stable while out_ready is low.
  - On out_valid && out_ready: go to IDLE in the next cycle. No new grant in the same cycle as result acceptance; the next grant is earliest one cycle after.
- Requester input changes:
  - a_sel / a_dir / a_data changing after acceptance have no effect on the active job.
  - A sel change while in IDLE with valid low is ignored.
- Reset mid-operation (any state): return to the reset values in the next cycle.
  - The in-flight job is discarded with no output.
  - out_valid deasserts immediately after the reset edge.
- rnd_* outputs when not in ROUND: rnd_idx = 0, rnd_last = 0; rnd_state holds its last value (don't-care for the datapath).
- Width rules:
  - Counter is 4 bits; it never exceeds 14.
  - Nr + 1 fits in 4 bits; no wrap occurs.

Test Plan:
- Single A encrypt, mode 00, data 00112233445566778899aabbccddeeff with the round function wired to the 128-bit encrypt datapath:
  - out_valid 12 cycles after a_ready.
  - out_data = 69c4e0d86a7b0430d8cdb78070b4c55a, out_id = 0.
- A and B valid in the same cycle from reset:
  - A granted first, B after A's result is taken; out_id sequence 0, 1.
  - With both held continuously valid, grants alternate A, B, A, B.
- Mode 1x decrypt of 8ea2b7ca516745bfeafc49904b496089 (256-bit key 00..1f):
  - rnd_idx steps 0..14, rnd_last high only at 14.
  - out_data = 00112233445566778899aabbccddeeff after 16 cycles.
- Backpressure:
  - Hold out_ready = 0 for 5 cycles in DONE: out_valid/out_data/out_id stable, a_ready and b_ready stay 0.
  - Raise out_ready: state returns to IDLE; a_ready is allowed no earlier than the following cycle.
- Reset asserted when rnd_idx = 6 of a mode-01 job:
  - Next cycle: busy = 0, out_valid = 0, rnd_idx = 0.
  - A fresh A job then completes normally with 14-cycle latency.
- Requester changes a_data and a_sel one cycle after acceptance: the result matches the originally latched values and the original Nr.
